// File: rtl/servo_pwm_driver.sv
// Servo bridge driver: turns the signed IPD output into a saturated duty plus a direction
// bit, and emits a fixed-period PWM whose duty changes only at period boundaries.
module servo_pwm_driver #(
  parameter int cant_bits = 16,
  parameter int FRAC_BITS = 8,
  parameter int PERIOD    = 1000,
  parameter int DUTY_MAX  = 900,
  localparam int YW = 2*cant_bits,
  localparam int CW = $clog2(PERIOD)
) (
  input  logic          Clk_G,
  input  logic          Rst_G,
  input  logic          Enable,
  input  logic [YW-1:0] Yk,
  input  logic          Yk_Valid,
  output logic          PWM_Out,
  output logic          Dir_Out,
  output logic          Sat_Flag,
  output logic          Period_Strobe,
  output logic [CW-1:0] Duty_Act
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] duty_pend_q, duty_pend_d;
  logic          dir_pend_q, dir_pend_d;
  logic          sat_pend_q, sat_pend_d;
  logic [CW-1:0] duty_act_q;
  logic          dir_act_q, sat_act_q;

  logic [YW-1:0] abs_yk, mag;
  logic          ovf, clip, wrap, apply;

  // Capture: the most negative Yk has no positive magnitude, so it is forced to saturate.
  always_comb begin
    abs_yk      = Yk[YW-1] ? -Yk : Yk;
    ovf         = (Yk == {1'b1, {(YW-1){1'b0}}});
    mag         = abs_yk >> (2*FRAC_BITS);
    clip        = ovf || (mag > YW'(DUTY_MAX));
    duty_pend_d = duty_pend_q;
    dir_pend_d  = dir_pend_q;
    sat_pend_d  = sat_pend_q;
    if (Yk_Valid) begin
      duty_pend_d = clip ? CW'(DUTY_MAX) : mag[CW-1:0];
      dir_pend_d  = Yk[YW-1];
      sat_pend_d  = clip;
    end
  end

  assign wrap = (cnt_q == CW'(PERIOD-1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    apply   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (Enable) begin
          state_d = S_RUN;
          apply   = 1'b1;
        end
      end
      S_RUN: begin
        if (wrap) begin
          cnt_d = '0;
          apply = 1'b1;
          if (!Enable) state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Active registers load from the old pending values, so a strobe on a wrap edge waits a period.
  always_ff @(posedge Clk_G) begin
    if (Rst_G) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      duty_pend_q <= '0;
      dir_pend_q  <= 1'b0;
      sat_pend_q  <= 1'b0;
      duty_act_q  <= '0;
      dir_act_q   <= 1'b0;
      sat_act_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      duty_pend_q <= duty_pend_d;
      dir_pend_q  <= dir_pend_d;
      sat_pend_q  <= sat_pend_d;
      if (apply) begin
        duty_act_q <= duty_pend_q;
        dir_act_q  <= dir_pend_q;
        sat_act_q  <= sat_pend_q;
      end
    end
  end

  assign PWM_Out       = (state_q == S_RUN) && (cnt_q < duty_act_q);
  assign Period_Strobe = (state_q == S_RUN) && wrap;
  assign Dir_Out       = dir_act_q;
  assign Sat_Flag      = sat_act_q;
  assign Duty_Act      = duty_act_q;

endmodule
